// File: rtl/encoder_8_to_3_pend_pkg.sv
// Shared constants, state encoding and helpers for the pending-request 8-to-3 encoder.
package encoder_8_to_3_pend_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE,
        PRESENT
    } state_e;

    function automatic logic [N_REQ-1:0] idx_mask(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/encoder_8_to_3_pend_if.sv
// Request/handshake bundle between a producer/consumer and the pending encoder.
interface encoder_8_to_3_pend_if;
    import encoder_8_to_3_pend_pkg::*;

    logic             E;
    logic [N_REQ-1:0] D;
    logic             ready;
    logic [IDX_W-1:0] A;
    logic             valid;
    logic [N_REQ-1:0] pending;
    logic             ovf;

    modport master (
        output E, D, ready,
        input  A, valid, pending, ovf
    );

    modport slave (
        input  E, D, ready,
        output A, valid, pending, ovf
    );

endinterface

// File: rtl/prio_enc_8_to_3.sv
// Combinational highest-set-bit encoder; index 0 has the lowest priority.
module prio_enc_8_to_3
    import encoder_8_to_3_pend_pkg::*;
(
    input  logic [N_REQ-1:0] D,
    output logic [IDX_W-1:0] A,
    output logic             any
);

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        A = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (D[i]) begin
                A = IDX_W'(i);
            end
        end
    end

    assign any = |D;

endmodule

// File: rtl/encoder_8_to_3_pend.sv
// Latches request pulses into a pending set and presents them one at a time,
// highest index first, over a valid/ready handshake.
module encoder_8_to_3_pend
    import encoder_8_to_3_pend_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    encoder_8_to_3_pend_if.slave bus
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] a_q, a_d;
    logic             valid_q, valid_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic             ovf_q, ovf_d;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] req;
    logic [IDX_W-1:0] enc_a;
    logic             enc_any;

    prio_enc_8_to_3 u_prio (
        .D   (pending_q),
        .A   (enc_a),
        .any (enc_any)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        valid_d = valid_q;
        clr     = '0;
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (!bus.E && enc_any) begin
                    a_d     = enc_a;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.ready) begin
                    clr     = idx_mask(a_q);
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
        req       = bus.E ? '0 : bus.D;
        // A fresh request on the accepted index survives the clear and is not an overflow.
        pending_d = (pending_q & ~clr) | req;
        ovf_d     = |(req & pending_q & ~clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.A       = a_q;
    assign bus.valid   = valid_q;
    assign bus.pending = pending_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_encoder_8_to_3_pend.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_encoder_8_to_3_pend;

    logic clk = 1'b0;
    logic rst;

    encoder_8_to_3_pend_if bus ();

    encoder_8_to_3_pend dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    logic [7:0] m_pending = '0;
    logic [2:0] m_a       = '0;
    logic       m_valid   = 1'b0;
    logic       m_ovf     = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare every output.
    task automatic step(input logic r, input logic e, input logic [7:0] d, input logic rdy);
        logic [7:0] np;
        logic [2:0] na;
        logic       nv;
        logic       no;
        logic       accept;
        logic       hit;
        logic       found;
        rst       = r;
        bus.E     = e;
        bus.D     = d;
        bus.ready = rdy;
        np = '0;
        na = m_a;
        nv = m_valid;
        no = 1'b0;
        if (r) begin
            na = '0;
            nv = 1'b0;
        end else begin
            accept = m_valid && rdy;
            for (int i = 0; i < 8; i++) begin
                hit = accept && (i == int'(m_a));
                if (!e && d[i] && m_pending[i] && !hit) no = 1'b1;
                np[i] = (m_pending[i] && !hit) || (!e && d[i]);
            end
            if (accept) begin
                nv = 1'b0;
            end else if (!m_valid && !e && m_pending != 8'h00) begin
                found = 1'b0;
                for (int i = 7; i >= 0; i--) begin
                    if (m_pending[i] && !found) begin
                        na    = 3'(i);
                        found = 1'b1;
                    end
                end
                nv = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        m_pending = np;
        m_a       = na;
        m_valid   = nv;
        m_ovf     = no;
        check("model_pending", bus.pending, m_pending);
        check("model_valid", {7'b0, bus.valid}, {7'b0, m_valid});
        check("model_A", {5'b0, bus.A}, {5'b0, m_a});
        check("model_ovf", {7'b0, bus.ovf}, {7'b0, m_ovf});
    endtask

    initial begin
        logic       r;
        logic       e;
        logic       rd;
        logic [7:0] d;

        rst       = 1'b1;
        bus.E     = 1'b1;
        bus.D     = '0;
        bus.ready = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("rst_A", {5'b0, bus.A}, 8'h00);
        check("rst_valid", {7'b0, bus.valid}, 8'h00);
        check("rst_pending", bus.pending, 8'h00);

        // Single request latency and acceptance
        step(1'b0, 1'b0, 8'h04, 1'b0);
        check("single_pend_n1", bus.pending, 8'h04);
        check("single_valid_n1", {7'b0, bus.valid}, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("single_valid_n2", {7'b0, bus.valid}, 8'h01);
        check("single_A_n2", {5'b0, bus.A}, 8'h02);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("single_pend_acc", bus.pending, 8'h00);
        check("single_valid_acc", {7'b0, bus.valid}, 8'h00);

        // Priority order 7, 4, 0 with ready held high
        step(1'b0, 1'b0, 8'h91, 1'b1);
        check("prio_pend", bus.pending, 8'h91);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("prio_A7", {4'b0, bus.valid, bus.A}, 8'h0f);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("prio_bubble1", {7'b0, bus.valid}, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("prio_A4", {4'b0, bus.valid, bus.A}, 8'h0c);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("prio_A0", {4'b0, bus.valid, bus.A}, 8'h08);
        check("prio_ovf", {7'b0, bus.ovf}, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("prio_empty", bus.pending, 8'h00);

        // Backpressure: A=5 held while bit 7 arrives
        step(1'b0, 1'b0, 8'h20, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("bp_A5", {4'b0, bus.valid, bus.A}, 8'h0d);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, (k == 0) ? 8'h80 : 8'h00, 1'b0);
            check("bp_hold", {4'b0, bus.valid, bus.A}, 8'h0d);
        end
        check("bp_pend", bus.pending, 8'ha0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("bp_acc_pend", bus.pending, 8'h80);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("bp_next_A7", {4'b0, bus.valid, bus.A}, 8'h0f);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Overflow on an already-pending bit, then new-request-wins on acceptance
        step(1'b0, 1'b0, 8'h08, 1'b0);
        step(1'b0, 1'b0, 8'h08, 1'b0);
        check("ovf_pulse", {7'b0, bus.ovf}, 8'h01);
        check("ovf_pend", bus.pending, 8'h08);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("ovf_one_cycle", {7'b0, bus.ovf}, 8'h00);
        step(1'b0, 1'b0, 8'h08, 1'b1);
        check("win_pend", bus.pending, 8'h08);
        check("win_no_ovf", {7'b0, bus.ovf}, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("win_repres", {4'b0, bus.valid, bus.A}, 8'h0b);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Disable: requests ignored, but an open handshake still completes
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 8'hff, 1'b0);
            check("dis_pend", bus.pending, 8'h00);
            check("dis_valid", {7'b0, bus.valid}, 8'h00);
        end
        step(1'b0, 1'b0, 8'h40, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check("dis_hold", {4'b0, bus.valid, bus.A}, 8'h0e);
        step(1'b0, 1'b1, 8'hff, 1'b1);
        check("dis_acc_valid", {7'b0, bus.valid}, 8'h00);
        check("dis_acc_pend", bus.pending, 8'h00);

        // Reset while presenting drops the request
        step(1'b0, 1'b0, 8'h30, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("mid_pre_pend", bus.pending, 8'h30);
        check("mid_pre_valid", {7'b0, bus.valid}, 8'h01);
        step(1'b1, 1'b0, 8'hff, 1'b1);
        check("mid_rst_all", {bus.ovf, bus.valid, bus.A, 3'b0}, 8'h00);
        check("mid_rst_pend", bus.pending, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("mid_after_valid", {7'b0, bus.valid}, 8'h00);
        check("mid_after_pend", bus.pending, 8'h00);

        // Random traffic against the model
        for (int k = 0; k < 500; k++) begin
            r  = ($urandom_range(0, 59) == 0);
            e  = ($urandom_range(0, 7) == 0);
            d  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            rd = 1'($urandom_range(0, 1));
            step(r, e, d, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/encoder_8_to_3_pend.md
ENCODER_8_TO_3_PEND -- requirements
Module: encoder_8_to_3_pend

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 E  input  1  active-low enable; 0 = operate, 1 = disabled.
REQ-005 D  input  8  request lines; bit i high for a cycle = request for index i.
REQ-006 ready  input  1  consumer accepts the presented index this cycle.
REQ-007 A  output  3  encoded index of the presented request, registered.
REQ-008 valid  output  1  A holds a request awaiting acceptance, registered.
REQ-009 pending  output  8  latched, not-yet-accepted requests, registered.
REQ-010 ovf  output  1  one-cycle pulse: request on a bit already pending, registered.

Function
REQ-011 When E=0, each cycle pending SHALL become pending OR D, minus any bit cleared by acceptance (REQ-016).
REQ-012 When E=1, pending SHALL ignore D but still clear accepted bits.
REQ-013 State machine SHALL have exactly two states: IDLE and PRESENT.
REQ-014 IDLE: if E=0 and pending nonzero, load A with the highest set index of pending, set valid=1, go to PRESENT; otherwise stay, valid=0.
REQ-015 PRESENT: A and valid SHALL hold stable until ready=1, regardless of E or new D.
REQ-016 PRESENT with ready=1: clear pending[A], set valid=0, go to IDLE next cycle.
REQ-017 If D[A]=1 with E=0 in the acceptance cycle, the new request SHALL win: pending[A] stays set, and ovf SHALL NOT pulse.
REQ-018 Latency: D[i] high in cycle n with empty pending, IDLE, E=0 -> pending[i]=1 in n+1, valid=1 with A=i in n+2.
REQ-019 Throughput: at most one acceptance per two cycles; one IDLE bubble always follows an acceptance.
REQ-020 Priority SHALL be fixed: highest index wins; index 0 has lowest priority.
REQ-021 ovf SHALL pulse for one cycle after any cycle where E=0 and D[i]=1 while pending[i]=1, except the case in REQ-017.
REQ-022 ready in IDLE SHALL be ignored.
REQ-023 A in IDLE SHALL hold its last value; A is meaningful only when valid=1.

Reset
REQ-024 rst=1 SHALL force IDLE, pending=0, A=0, valid=0, ovf=0 at the next edge, overriding D, E and ready.
REQ-025 Reset during PRESENT SHALL drop the request without acceptance.

Structure
REQ-026 A shared package SHALL hold N_REQ=8, IDX_W=3, and the state enum {IDLE, PRESENT}.
REQ-027 Highest-set-bit encoding SHALL be a combinational sub-module prio_enc_8_to_3 with inputs D[7:0] and outputs A[2:0] and any.

Verification
REQ-028 Single request: E=0, D=8'h04 for 1 cycle -> pending=8'h04 at n+1; valid=1, A=2 at n+2; ready=1 -> pending=0, valid=0.
REQ-029 Priority order: D=8'h91 at once, ready always 1 -> A sequence 7, 4, 0, two cycles apart; ovf stays 0.
REQ-030 Backpressure: A=5 presented, ready=0 for 10 cycles while D=8'h80 arrives -> A=5 and valid stay stable; after acceptance, next A=7.
REQ-031 Overflow: pending[3]=1, D=8'h08 again -> ovf=1 for exactly one cycle; pending unchanged.
REQ-032 Disable: E=1, D=8'hFF -> pending stays 0 and valid stays 0; E=1 during PRESENT -> handshake still completes on ready.
REQ-033 Reset mid-operation: valid=1, pending=8'h30, rst=1 for 1 cycle -> all outputs 0 and state IDLE next cycle; ready afterwards has no effect.
